// File: rtl/ps2_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// ps2_cmd_sequencer_if
// Groups the user command port and the PS/2 transmitter/receiver signals of
// the command sequencer.
//
// Handshake semantics:
//   usr_req is a level request that the user holds, with usr_cmd stable, until
//   a one-cycle usr_gnt pulse is seen. usr_cmd is captured on the clock edge
//   that raises usr_gnt. The request then ends with exactly one usr_done
//   (ACKed) or one usr_err (retries exhausted) pulse. tx_send is a toggle
//   line, so each level change asks for one frame. A rising edge on tx_ok
//   means that frame has left the transmitter. rx_valid qualifies rx_byte for
//   exactly one cycle.
//
// Modports:
//   master - the sequencer side (drives grant/status pulses, frame, send)
//   slave  - the environment side (user logic, transmitter, receiver)
// ----------------------------------------------------------------------------
interface ps2_cmd_sequencer_if;
    logic        usr_req;
    logic [7:0]  usr_cmd;
    logic        usr_gnt;
    logic        usr_done;
    logic        usr_err;
    logic [10:0] tx_frame;
    logic        tx_send;
    logic        tx_ok;
    logic        rx_valid;
    logic [7:0]  rx_byte;

    modport master (
        input  usr_req, usr_cmd, tx_ok, rx_valid, rx_byte,
        output usr_gnt, usr_done, usr_err, tx_frame, tx_send
    );

    modport slave (
        output usr_req, usr_cmd, tx_ok, rx_valid, rx_byte,
        input  usr_gnt, usr_done, usr_err, tx_frame, tx_send
    );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_cmd_sequencer
// Schedules host-to-device commands for a shared PS/2 transmitter. Arbitrates
// between the built-in mouse init sequence (0xFF, 0xEA, 0xF4) and a user
// command port, builds the 11-bit frame, toggles the transmitter's send line,
// checks the device reply and retries or fails.
//
// Ports:
//   qzt_clk    - system clock (25 MHz)
//   rst_n      - asynchronous active-low reset
//   init_start - rising edge requests the init sequence
//   bus        - user port + transmitter/receiver signals (master modport)
//   busy       - high whenever the FSM is not in IDLE
//   init_done  - init sequence completed (cleared when a new init starts)
//   init_fail  - init sequence aborted  (cleared when a new init starts)
//   dbg_state  - current FSM state encoding
// ----------------------------------------------------------------------------
module ps2_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES     = 500_000,
    parameter int unsigned BAT_TIMEOUT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES         = 25_000,
    parameter int unsigned MAX_RETRY          = 3
) (
    input  logic                       qzt_clk,
    input  logic                       rst_n,
    input  logic                       init_start,
    ps2_cmd_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       init_done,
    output logic                       init_fail,
    output logic [3:0]                 dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_SEND     = 4'd2,
        S_WAIT_TX  = 4'd3,
        S_WAIT_ACK = 4'd4,
        S_WAIT_BAT = 4'd5,
        S_WAIT_ID  = 4'd6,
        S_GAP      = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    // Timeouts fire on the last cycle of the allowed window.
    localparam logic [24:0] L_TMO_LAST = 25'(TIMEOUT_CYCLES - 1);
    localparam logic [24:0] L_BAT_LAST = 25'(BAT_TIMEOUT_CYCLES - 1);
    localparam logic [24:0] L_GAP_LAST = 25'(GAP_CYCLES - 1);
    localparam logic [1:0]  L_MAX_RETRY = 2'(MAX_RETRY);

    function automatic logic [7:0] f_init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'hFF;   // reset, device answers FA, AA, 00
            2'd1:    return 8'hEA;   // set stream mode
            default: return 8'hF4;   // enable data reporting
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next;
    state_t      w_retry_state;

    logic [24:0] r_timer;
    logic [1:0]  r_retry;
    logic [1:0]  r_ptr;
    logic        r_is_init;
    logic [7:0]  r_usr_byte;
    logic [10:0] r_tx_frame;
    logic        r_tx_send;
    logic        r_usr_gnt;
    logic        r_usr_done;
    logic        r_usr_err;
    logic        r_init_done;
    logic        r_init_fail;
    logic        r_init_pend;

    logic        r_edge_primed;
    logic        r_init_new;
    logic        r_init_old;
    logic        r_txok_new;
    logic        r_txok_old;

    logic        w_init_edge;
    logic        w_init_inflight;
    logic        w_txok_edge;
    logic        w_init_req;
    logic        w_can_retry;
    logic        w_tmo_short;
    logic        w_tmo_bat;
    logic        w_tmo_gap;
    logic [7:0]  w_sel_byte;
    logic        w_rx_fa;
    logic        w_rx_nak;

    logic        w_grant;
    logic        w_start_init;
    logic        w_load;
    logic        w_send;
    logic        w_retry_inc;
    logic        w_ptr_inc;
    logic        w_set_done;
    logic        w_set_fail;
    logic        w_usr_done;
    logic        w_usr_err;

    assign w_init_edge = r_init_new & ~r_init_old;
    assign w_txok_edge = r_txok_new & ~r_txok_old;
    // An init_start rise that the edge registers have not captured yet still
    // outranks a user request seen in the same cycle.
    assign w_init_inflight = init_start & ~r_init_new;
    assign w_init_req  = w_init_edge | r_init_pend;
    assign w_can_retry = (r_retry < L_MAX_RETRY);
    assign w_tmo_short = (r_timer == L_TMO_LAST);
    assign w_tmo_bat   = (r_timer == L_BAT_LAST);
    assign w_tmo_gap   = (r_timer == L_GAP_LAST);
    assign w_sel_byte  = r_is_init ? f_init_rom(r_ptr) : r_usr_byte;
    assign w_rx_fa     = bus.rx_valid && (bus.rx_byte == 8'hFA);
    assign w_rx_nak    = bus.rx_valid && ((bus.rx_byte == 8'hFE) || (bus.rx_byte == 8'hFC));

    // ---------------- state register ----------------
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next state and control strobes ----------------
    always_comb begin
        w_next        = r_state;
        w_retry_state = w_can_retry ? S_SEND : S_FAIL;
        w_grant       = 1'b0;
        w_start_init  = 1'b0;
        w_load        = 1'b0;
        w_send        = 1'b0;
        w_retry_inc   = 1'b0;
        w_ptr_inc     = 1'b0;
        w_set_done    = 1'b0;
        w_set_fail    = 1'b0;
        w_usr_done    = 1'b0;
        w_usr_err     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_init_req) begin
                    w_next       = S_LOAD;
                    w_start_init = 1'b1;
                end else if (bus.usr_req && !w_init_inflight) begin
                    w_next  = S_LOAD;
                    w_grant = 1'b1;
                end
            end
            S_LOAD: begin
                w_next = S_SEND;
                w_load = 1'b1;
            end
            S_SEND: begin
                w_next = S_WAIT_TX;
                w_send = 1'b1;
            end
            S_WAIT_TX: begin
                if (w_txok_edge) begin
                    w_next = S_WAIT_ACK;
                end else if (w_tmo_short) begin
                    w_next      = w_retry_state;
                    w_retry_inc = w_can_retry;
                end
            end
            S_WAIT_ACK: begin
                if (w_rx_fa) begin
                    // Only a reset command is followed by self-test and ID.
                    w_next = (r_tx_frame[8:1] == 8'hFF) ? S_WAIT_BAT : S_GAP;
                end else if (w_rx_nak || w_tmo_short) begin
                    w_next      = w_retry_state;
                    w_retry_inc = w_can_retry;
                end
            end
            S_WAIT_BAT: begin
                if (bus.rx_valid && (bus.rx_byte == 8'hAA)) begin
                    w_next = S_WAIT_ID;
                end else if ((bus.rx_valid && (bus.rx_byte == 8'hFC)) || w_tmo_bat) begin
                    w_next = S_FAIL;
                end
            end
            S_WAIT_ID: begin
                if (bus.rx_valid && (bus.rx_byte == 8'h00)) begin
                    w_next = S_GAP;
                end else if (w_tmo_bat) begin
                    w_next = S_FAIL;
                end
            end
            S_GAP: begin
                if (w_tmo_gap) begin
                    if (!r_is_init) begin
                        w_next     = S_IDLE;
                        w_usr_done = 1'b1;
                    end else if (r_ptr < 2'd2) begin
                        w_next    = S_LOAD;
                        w_ptr_inc = 1'b1;
                    end else begin
                        w_next     = S_IDLE;
                        w_set_done = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                w_next     = S_IDLE;
                w_set_fail = r_is_init;
                w_usr_err  = ~r_is_init;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer       <= '0;
            r_retry       <= '0;
            r_ptr         <= '0;
            r_is_init     <= 1'b0;
            r_usr_byte    <= '0;
            r_tx_frame    <= 11'h7FF;
            r_tx_send     <= 1'b0;
            r_usr_gnt     <= 1'b0;
            r_usr_done    <= 1'b0;
            r_usr_err     <= 1'b0;
            r_init_done   <= 1'b0;
            r_init_fail   <= 1'b0;
            r_init_pend   <= 1'b0;
            r_edge_primed <= 1'b0;
            r_init_new    <= 1'b0;
            r_init_old    <= 1'b0;
            r_txok_new    <= 1'b0;
            r_txok_old    <= 1'b0;
        end else begin
            // The first clock after reset loads both stages from the input,
            // so a level that was already high is not taken as an edge.
            r_edge_primed <= 1'b1;
            r_init_new    <= init_start;
            r_init_old    <= r_edge_primed ? r_init_new : init_start;
            r_txok_new    <= bus.tx_ok;
            r_txok_old    <= r_edge_primed ? r_txok_new : bus.tx_ok;

            // One-deep memory of an init request that could not be served yet.
            r_init_pend <= (r_init_pend | w_init_edge) & ~w_start_init;

            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 25'd1;
            end

            r_usr_gnt  <= w_grant;
            r_usr_done <= w_usr_done;
            r_usr_err  <= w_usr_err;

            if (w_start_init) begin
                r_is_init   <= 1'b1;
                r_ptr       <= 2'd0;
                r_init_done <= 1'b0;
                r_init_fail <= 1'b0;
            end else if (w_grant) begin
                r_is_init  <= 1'b0;
                r_usr_byte <= bus.usr_cmd;
            end

            if (w_ptr_inc)  r_ptr       <= r_ptr + 2'd1;
            if (w_set_done) r_init_done <= 1'b1;
            if (w_set_fail) r_init_fail <= 1'b1;

            if (w_load) begin
                r_tx_frame <= {1'b1, ~^w_sel_byte, w_sel_byte, 1'b0};
                r_retry    <= 2'd0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 2'd1;
            end

            if (w_send) r_tx_send <= ~r_tx_send;
        end
    end

    assign bus.usr_gnt  = r_usr_gnt;
    assign bus.usr_done = r_usr_done;
    assign bus.usr_err  = r_usr_err;
    assign bus.tx_frame = r_tx_frame;
    assign bus.tx_send  = r_tx_send;
    assign busy         = (r_state != S_IDLE);
    assign init_done    = r_init_done;
    assign init_fail    = r_init_fail;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ps2_cmd_sequencer
// Directed-plus-random bench: a transmitter/device model is driven inline from
// one initial block; expected frames and outcomes come from the command rules
// (odd parity by counting ones, retry budget, init byte list).
// ----------------------------------------------------------------------------
module tb_ps2_cmd_sequencer;

    localparam int TMO  = 40;
    localparam int BAT  = 120;
    localparam int GAP  = 10;
    localparam int MAXR = 3;

    logic       clk;
    logic       rst_n;
    logic       init_start;
    logic       busy;
    logic       init_done;
    logic       init_fail;
    logic [3:0] dbg_state;

    ps2_cmd_sequencer_if bus();

    ps2_cmd_sequencer #(
        .TIMEOUT_CYCLES    (TMO),
        .BAT_TIMEOUT_CYCLES(BAT),
        .GAP_CYCLES        (GAP),
        .MAX_RETRY         (MAXR)
    ) dut (
        .qzt_clk   (clk),
        .rst_n     (rst_n),
        .init_start(init_start),
        .bus       (bus),
        .busy      (busy),
        .init_done (init_done),
        .init_fail (init_fail),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitors ----------------
    int   n_assert = 0;
    int   n_fail   = 0;
    int   tog_cnt  = 0;
    int   gnt_cnt  = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   tog_cyc  = 0;
    int   gnt_cyc  = 0;
    logic prev_send = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_send !== prev_send) begin
            tog_cnt = tog_cnt + 1;
            tog_cyc = cyc;
        end
        prev_send = bus.tx_send;
        if (bus.usr_gnt === 1'b1) begin
            gnt_cnt = gnt_cnt + 1;
            gnt_cyc = cyc;
        end
        if (bus.usr_done === 1'b1) done_cnt = done_cnt + 1;
        if (bus.usr_err === 1'b1)  err_cnt  = err_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [7:0] init_bytes [3] = '{8'hFF, 8'hEA, 8'hF4};

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        // odd parity: data ones plus parity bit must be odd
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        model_frame = {1'b1, par, b, 1'b0};
    endfunction

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        b = 8'(($urandom_range(0, 255)));
        while (b == 8'hFA || b == 8'hFE || b == 8'hFC) b = 8'(($urandom_range(0, 255)));
        return b;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_toggle(input int budget, output bit seen);
        int start;
        start = tog_cnt;
        seen  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tog_cnt != start) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_gnt(input int budget, output bit seen);
        int start;
        start = gnt_cnt;
        seen  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (gnt_cnt != start) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy === 1'b0) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic tx_ack();
        repeat ($urandom_range(1, 4)) tick();
        bus.tx_ok = 1'b1;
        tick();
        tick();
        bus.tx_ok = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        repeat ($urandom_range(1, 3)) tick();
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'(($urandom_range(0, 255)));
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
    endtask

    task automatic run_init_ok();
        bit seen;
        for (int i = 0; i < 3; i++) begin
            wait_toggle(GAP + 30, seen);
            chk("init_tog_seen", seen, 1);
            chk("init_frame", bus.tx_frame, model_frame(init_bytes[i]));
            if (i == 0) chk("init_flags_cleared", {init_done, init_fail}, 0);
            tx_ack();
            send_rx(noise_byte());
            send_rx(8'hFA);
            if (init_bytes[i] == 8'hFF) begin
                send_rx(8'hAA);
                send_rx(8'h00);
            end
        end
    endtask

    task automatic run_user(input logic [7:0] cmd, input int naks);
        int  d0, e0, t0, attempts;
        bit  seen, expect_ok;
        d0 = done_cnt;
        e0 = err_cnt;
        t0 = tog_cnt;
        expect_ok = (naks <= MAXR);
        attempts  = expect_ok ? naks + 1 : MAXR + 1;
        bus.usr_cmd = cmd;
        bus.usr_req = 1'b1;
        wait_gnt(20, seen);
        chk("usr_gnt_seen", seen, 1);
        bus.usr_req = 1'b0;
        bus.usr_cmd = 8'(($urandom_range(0, 255)));
        for (int a = 0; a < attempts; a++) begin
            wait_toggle(TMO + 10, seen);
            chk("usr_tog_seen", seen, 1);
            if (a == 0) chk("gnt_to_send_cycles", 32'(tog_cyc - gnt_cyc), 2);
            chk("usr_frame", bus.tx_frame, model_frame(cmd));
            tx_ack();
            if (a < naks) send_rx(($urandom_range(0, 1) == 1) ? 8'hFE : 8'hFC);
            else          send_rx(8'hFA);
        end
        // A byte during GAP must be dropped.
        if (expect_ok) send_rx(8'hFE);
        wait_idle(GAP + 40, seen);
        chk("usr_back_idle", seen, 1);
        chk("usr_done_count", 32'(done_cnt - d0), expect_ok ? 1 : 0);
        chk("usr_err_count", 32'(err_cnt - e0), expect_ok ? 0 : 1);
        chk("usr_toggle_count", 32'(tog_cnt - t0), 32'(attempts));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  d0, e0, t0, g0, prev_tc, sp;
        bit  seen;
        logic [7:0] cmd;

        rst_n        = 1'b0;
        init_start   = 1'b0;
        bus.usr_req  = 1'b0;
        bus.usr_cmd  = 8'h00;
        bus.tx_ok    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        repeat (3) tick();

        // Reset values
        chk("rst_tx_send", bus.tx_send, 0);
        chk("rst_tx_frame", bus.tx_frame, 11'h7FF);
        chk("rst_busy", busy, 0);
        chk("rst_init_flags", {init_done, init_fail}, 0);
        chk("rst_pulses", {bus.usr_gnt, bus.usr_done, bus.usr_err}, 0);
        chk("rst_dbg_state", dbg_state, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Init happy path
        t0 = tog_cnt;
        pulse_init();
        run_init_ok();
        wait_idle(GAP + 40, seen);
        chk("init_idle", seen, 1);
        chk("init_done_set", init_done, 1);
        chk("init_fail_clear", init_fail, 0);
        chk("init_toggles", 32'(tog_cnt - t0), 3);

        // Resend: two NAKs then ACK
        run_user(8'hF3, 2);

        // Random user commands, NAK counts across the retry budget
        for (int k = 0; k < 6; k++) begin
            cmd = 8'(($urandom_range(0, 254)));
            run_user(cmd, (k == 5) ? 4 : $urandom_range(0, 4));
        end

        // ACK timeout: frame sent each time, device silent
        d0 = done_cnt;
        e0 = err_cnt;
        t0 = tog_cnt;
        bus.usr_cmd = 8'hF4;
        bus.usr_req = 1'b1;
        wait_gnt(20, seen);
        chk("tmo_gnt_seen", seen, 1);
        bus.usr_req = 1'b0;
        prev_tc = 0;
        for (int a = 0; a <= MAXR; a++) begin
            wait_toggle(TMO + 20, seen);
            chk("tmo_tog_seen", seen, 1);
            chk("tmo_frame", bus.tx_frame, model_frame(8'hF4));
            if (a > 0) begin
                sp = tog_cyc - prev_tc;
                chk("tmo_spacing_in_window", 32'((sp >= TMO) && (sp <= TMO + 12)), 1);
            end
            prev_tc = tog_cyc;
            tx_ack();
        end
        wait_idle(TMO + 20, seen);
        chk("tmo_idle", seen, 1);
        chk("tmo_err_count", 32'(err_cnt - e0), 1);
        chk("tmo_done_count", 32'(done_cnt - d0), 0);
        chk("tmo_toggles", 32'(tog_cnt - t0), 32'(MAXR + 1));

        // BAT timeout: ACK for 0xFF, then silence
        t0 = tog_cnt;
        pulse_init();
        wait_toggle(30, seen);
        chk("bat_tog_seen", seen, 1);
        chk("bat_frame", bus.tx_frame, model_frame(8'hFF));
        chk("bat_init_done_cleared", init_done, 0);
        tx_ack();
        send_rx(8'hFA);
        wait_idle(BAT + 40, seen);
        chk("bat_idle", seen, 1);
        chk("bat_init_fail", init_fail, 1);
        chk("bat_init_done", init_done, 0);
        chk("bat_no_more_frames", 32'(tog_cnt - t0), 1);

        // Arbitration: init and user request in the same cycle
        cmd = 8'(($urandom_range(0, 254)));
        d0 = done_cnt;
        g0 = gnt_cnt;
        init_start  = 1'b1;
        bus.usr_req = 1'b1;
        bus.usr_cmd = cmd;
        tick();
        init_start = 1'b0;
        run_init_ok();
        chk("arb_no_gnt_during_init", 32'(gnt_cnt - g0), 0);
        wait_gnt(GAP + 40, seen);
        chk("arb_gnt_seen", seen, 1);
        chk("arb_init_done_before_gnt", init_done, 1);
        bus.usr_req = 1'b0;
        wait_toggle(20, seen);
        chk("arb_usr_tog_seen", seen, 1);
        chk("arb_usr_frame", bus.tx_frame, model_frame(cmd));
        tx_ack();
        send_rx(8'hFA);
        wait_idle(GAP + 40, seen);
        chk("arb_usr_done", 32'(done_cnt - d0), 1);

        // Reset in WAIT_ACK
        d0 = done_cnt;
        bus.usr_cmd = 8'hE8;
        bus.usr_req = 1'b1;
        wait_gnt(20, seen);
        chk("rstmid_gnt_seen", seen, 1);
        bus.usr_req = 1'b0;
        wait_toggle(20, seen);
        chk("rstmid_tog_seen", seen, 1);
        tx_ack();
        tick();
        tick();
        chk("rstmid_in_wait_ack", dbg_state, 4);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_tx_send", bus.tx_send, 0);
        chk("rstmid_tx_frame", bus.tx_frame, 11'h7FF);
        chk("rstmid_busy_state", {busy, dbg_state}, 0);
        chk("rstmid_init_flags", {init_done, init_fail}, 0);
        chk("rstmid_pulses", {bus.usr_gnt, bus.usr_done, bus.usr_err}, 0);
        tick();
        rst_n = 1'b1;
        send_rx(8'hFA);
        repeat (GAP + 20) tick();
        chk("rstmid_no_done", 32'(done_cnt - d0), 0);
        chk("rstmid_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
